// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB receive decoder.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package usb_rx_pkg;

  localparam int STUFF_LIMIT_DEFAULT  = 6;
  localparam int CLKS_PER_BIT_DEFAULT = 8;

  // Receiver FSM encoding, kept as plain constants for legacy compatibility.
  typedef logic [1:0] rx_state_t;
  localparam rx_state_t IDLE     = 2'd0;
  localparam rx_state_t RECV     = 2'd1;
  localparam rx_state_t EOP_WAIT = 2'd2;

  // Line symbols seen on the synchronized (D+, D-) pair.
  typedef enum logic [1:0] {
    SYM_J   = 2'd0,
    SYM_K   = 2'd1,
    SYM_SE0 = 2'd2
  } line_sym_t;

  // Classify the line; the illegal (1,1) pair is treated as J.
  function automatic line_sym_t to_sym(input logic dp, input logic dm);
    if (!dp && !dm) begin
      return SYM_SE0;
    end else if (!dp && dm) begin
      return SYM_K;
    end else begin
      return SYM_J;
    end
  endfunction

endpackage

// File: rtl/usb_rx_decode_sync.sv
// Two-flop synchronizer for one raw USB line, with a selectable idle/reset level.
// Latency: 2 clk cycles from input change to sync_o.
// Backpressure: none; samples every cycle, clear_i forces the reset level.
module usb_sync
  import usb_rx_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous line.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else if (clear_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/usb_rx_decode.sv
// USB receive decoder: line sync, bit-clock recovery, NRZI decode, destuffing, EOP detect.
// Latency: first bit 2 sync + CLKS_PER_BIT/2 + 1 cycles after the SYNC J->K edge; then one bit per bit time.
// Backpressure: none; outputs are single-cycle strobes. Macro USB_RX_STUFF_CHECK_EN makes a stuffed 1 an error.
module usb_rx_decode
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int STUFF_LIMIT  = STUFF_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic d_plus,
  input  logic d_minus,
  output logic d_orig,
  output logic bit_valid,
  output logic eop,
  output logic rx_err,
  output logic receiving
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(STUFF_LIMIT + 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_LIM  = CW'(STUFF_LIMIT);

  logic      dp_s, dm_s;
  line_sym_t sym;
  logic      edge_det, sample, cur_j, dec_bit;

  rx_state_t       state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   ones_q, ones_d;
  logic [1:0]      se0_q, se0_d;
  logic            prev_line_q, prev_line_d;
  logic            dp_prev_q;
  logic            d_orig_q, d_orig_d;
  logic            bit_vld_q, bit_vld_d;
  logic            eop_q, eop_d;
  logic            err_q, err_d;

  // Idle bus is J, so D+ resets high and D- low.
  usb_sync #(.RST_VAL(1'b1)) u_sync_dp (
    .clk(clk), .n_rst(n_rst), .clear_i(clear), .async_i(d_plus), .sync_o(dp_s)
  );
  usb_sync #(.RST_VAL(1'b0)) u_sync_dm (
    .clk(clk), .n_rst(n_rst), .clear_i(clear), .async_i(d_minus), .sync_o(dm_s)
  );

  assign sym      = to_sym(dp_s, dm_s);
  assign cur_j    = (sym == SYM_J);
  // A D+ change into J or K is a bit boundary; changes into SE0 are not used for timing.
  assign edge_det = (dp_s != dp_prev_q) && (sym != SYM_SE0);
  // Resync takes priority over a coincident sample point.
  assign sample   = (state_q != IDLE) && (timer_q == T_HALF) && !edge_det;
  // NRZI: unchanged line is 1, transition is 0.
  assign dec_bit  = (cur_j == prev_line_q);

  // Next-state: bit timer, FSM, NRZI reference, stuff and SE0 counters, output strobes.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    ones_d      = ones_q;
    se0_d       = se0_q;
    prev_line_d = prev_line_q;
    d_orig_d    = 1'b0;
    bit_vld_d   = 1'b0;
    eop_d       = 1'b0;
    err_d       = 1'b0;

    if (state_q == IDLE) begin
      timer_d = '0;
    end else if (edge_det) begin
      timer_d = '0;
    end else begin
      timer_d = (timer_q == T_LAST) ? '0 : timer_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (edge_det && (sym == SYM_K)) begin
          state_d = RECV;
        end
      end
      RECV: begin
        if (sample) begin
          if (sym == SYM_SE0) begin
            state_d = EOP_WAIT;
            se0_d   = 2'd1;
          end else begin
            prev_line_d = cur_j;
            if (ones_q == C_LIM) begin
              if (!dec_bit) begin
                ones_d = '0;
              end else begin
`ifdef USB_RX_STUFF_CHECK_EN
                err_d       = 1'b1;
                state_d     = IDLE;
                prev_line_d = 1'b1;
                ones_d      = '0;
                se0_d       = '0;
`else
                ones_d = '0;
`endif
              end
            end else begin
              bit_vld_d = 1'b1;
              d_orig_d  = dec_bit;
              ones_d    = dec_bit ? ones_q + 1'b1 : '0;
            end
          end
        end
      end
      EOP_WAIT: begin
        if (sample) begin
          if (sym == SYM_SE0) begin
            se0_d = (se0_q == 2'd3) ? 2'd3 : se0_q + 2'd1;
          end else begin
            if ((sym == SYM_J) && (se0_q >= 2'd2)) begin
              eop_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d     = IDLE;
            prev_line_d = 1'b1;
            ones_d      = '0;
            se0_d       = '0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        prev_line_d = 1'b1;
        ones_d      = '0;
        se0_d       = '0;
      end
    endcase
  end

  // State and registered outputs; clear behaves exactly like reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      ones_q      <= '0;
      se0_q       <= '0;
      prev_line_q <= 1'b1;
      dp_prev_q   <= 1'b1;
      d_orig_q    <= 1'b0;
      bit_vld_q   <= 1'b0;
      eop_q       <= 1'b0;
      err_q       <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      ones_q      <= '0;
      se0_q       <= '0;
      prev_line_q <= 1'b1;
      dp_prev_q   <= 1'b1;
      d_orig_q    <= 1'b0;
      bit_vld_q   <= 1'b0;
      eop_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ones_q      <= ones_d;
      se0_q       <= se0_d;
      prev_line_q <= prev_line_d;
      dp_prev_q   <= dp_s;
      d_orig_q    <= d_orig_d;
      bit_vld_q   <= bit_vld_d;
      eop_q       <= eop_d;
      err_q       <= err_d;
    end
  end

  assign d_orig    = d_orig_q;
  assign bit_valid = bit_vld_q;
  assign eop       = eop_q;
  assign rx_err    = err_q;
  assign receiving = (state_q != IDLE);

endmodule

// File: tb/tb_usb_rx_decode.sv
// Scoreboard bench for usb_rx_decode: NRZI/stuffing line driver plus output monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_usb_rx_decode;
  import usb_rx_pkg::*;

  localparam int CPB    = 8;
  localparam int EV_B0  = 0;
  localparam int EV_B1  = 1;
  localparam int EV_EOP = 2;
  localparam int EV_ERR = 3;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic clear = 1'b0;
  logic d_plus = 1'b1;
  logic d_minus = 1'b0;
  logic d_orig, bit_valid, eop, rx_err, receiving;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  logic tx_lvl = 1'b1;
  int tx_ones = 0;
  bit slow = 1'b0;
  int bit_idx = 0;
  logic [63:0] payload = 64'hF0F3_FFC8_A5FF_0137;

  usb_rx_decode #(.CLKS_PER_BIT(CPB), .STUFF_LIMIT(6)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .d_plus(d_plus), .d_minus(d_minus),
    .d_orig(d_orig), .bit_valid(bit_valid), .eop(eop), .rx_err(rx_err), .receiving(receiving)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every output strobe.
  always @(negedge clk) begin
    int nact;
    int got;
    if (n_rst) begin
      nact = 32'(bit_valid) + 32'(eop) + 32'(rx_err);
      if (nact != 0) begin
        check("strobe_exclusive", 32'(nact), 32'd1);
        got = eop ? EV_EOP : (rx_err ? EV_ERR : (d_orig ? EV_B1 : EV_B0));
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got event %0d expected none", got);
        end else begin
          check("event", 32'(got), 32'(exp_q.pop_front()));
        end
        if (bit_valid) check("receiving_on_bit", 32'(receiving), 32'd1);
        if (eop || rx_err) check("receiving_on_end", 32'(receiving), 32'd0);
      end
    end
  end

  task automatic line(input line_sym_t s, input int n);
    case (s)
      SYM_J:   {d_plus, d_minus} = 2'b10;
      SYM_K:   {d_plus, d_minus} = 2'b01;
      default: {d_plus, d_minus} = 2'b00;
    endcase
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Slow mode stretches every fourth bit by one clock (8.25 clk average).
  task automatic line_bit(input line_sym_t s);
    int n;
    n = (slow && (bit_idx % 4 == 3)) ? CPB + 1 : CPB;
    bit_idx++;
    line(s, n);
  endtask

  task automatic send_lvl(input logic lvl);
    line_bit(lvl ? SYM_J : SYM_K);
  endtask

  // Transmit-side NRZI encode with bit stuffing after six 1s.
  task automatic send_data(input logic b, input bit expect_it);
    if (!b) tx_lvl = ~tx_lvl;
    if (expect_it) exp_q.push_back(b ? EV_B1 : EV_B0);
    send_lvl(tx_lvl);
    if (b) tx_ones++;
    else tx_ones = 0;
    if (tx_ones == 6) begin
      tx_lvl = ~tx_lvl;
      send_lvl(tx_lvl);
      tx_ones = 0;
    end
  endtask

  task automatic send_sync();
    tx_lvl = 1'b1;
    tx_ones = 0;
    repeat (7) send_data(1'b0, 1'b1);
    send_data(1'b1, 1'b1);
  endtask

  task automatic send_eop(input int n_se0);
    repeat (n_se0) line_bit(SYM_SE0);
    exp_q.push_back((n_se0 >= 2) ? EV_EOP : EV_ERR);
    line_bit(SYM_J);
    tx_lvl = 1'b1;
    repeat (3) line_bit(SYM_J);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", 32'({d_orig, bit_valid, eop, rx_err, receiving}), 32'd0);
    n_rst = 1'b1;
    line(SYM_J, 4 * CPB);
    check("idle_not_receiving", 32'(receiving), 32'd0);

    // SYNC then a good EOP.
    send_sync();
    send_eop(2);

    // Eight 1s; the transmitter inserts a stuffed 0 that must vanish.
    send_sync();
    repeat (8) send_data(1'b1, 1'b1);
    send_eop(2);

    // Stuff violation: seven unchanged line bits after SYNC.
    send_sync();
    for (int i = 0; i < 7; i++) begin
`ifdef USB_RX_STUFF_CHECK_EN
      if (i < 5) exp_q.push_back(EV_B1);
      else if (i == 5) exp_q.push_back(EV_ERR);
`else
      if (i != 5) exp_q.push_back(EV_B1);
`endif
      send_lvl(tx_lvl);
    end
`ifdef USB_RX_STUFF_CHECK_EN
    repeat (4) line_bit(SYM_J);
    tx_lvl = 1'b1;
`else
    send_eop(2);
`endif

    // 3% slow transmitter, 64-bit payload.
    slow = 1'b1;
    bit_idx = 0;
    send_sync();
    for (int i = 0; i < 64; i++) send_data(payload[i], 1'b1);
    send_eop(3);
    slow = 1'b0;

    // Single SE0 then J is a malformed EOP.
    send_sync();
    send_eop(1);

    // Asynchronous reset mid-payload.
    send_sync();
    send_data(1'b1, 1'b1);
    send_data(1'b0, 1'b1);
    send_data(1'b1, 1'b1);
    line(tx_lvl ? SYM_J : SYM_K, 3);
    check("pre_rst_drained", 32'(exp_q.size()), 32'd0);
    check("pre_rst_receiving", 32'(receiving), 32'd1);
    n_rst = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({d_orig, bit_valid, eop, rx_err, receiving}), 32'd0);
    {d_plus, d_minus} = 2'b10;
    repeat (3) @(posedge clk);
    #2;
    n_rst = 1'b1;
    line(SYM_J, 2 * CPB);
    check("post_rst_idle", 32'(receiving), 32'd0);
    send_sync();
    send_data(1'b0, 1'b1);
    send_data(1'b1, 1'b1);
    send_eop(2);

    // Synchronous clear mid-payload.
    send_sync();
    send_data(1'b0, 1'b1);
    send_data(1'b1, 1'b1);
    line(tx_lvl ? SYM_J : SYM_K, 3);
    check("pre_clr_drained", 32'(exp_q.size()), 32'd0);
    check("pre_clr_receiving", 32'(receiving), 32'd1);
    clear = 1'b1;
    {d_plus, d_minus} = 2'b10;
    @(posedge clk);
    #1;
    check("clr_outputs", 32'({d_orig, bit_valid, eop, rx_err, receiving}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;
    line(SYM_J, 2 * CPB);
    check("post_clr_idle", 32'(receiving), 32'd0);
    send_sync();
    send_data(1'b1, 1'b1);
    send_data(1'b0, 1'b1);
    send_data(1'b0, 1'b1);
    send_eop(2);

    line(SYM_J, 4 * CPB);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
